// File: rtl/serial_bit_source_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_bit_source_pkg
//  Brief    : Shared state encodings and sizing helper for the serial bit
//             source (parallel-to-serial stage feeding the sequence detector).
//  Revision : 1.0  initial release
// ============================================================================
package serial_bit_source_pkg;

   // One-bit state encoding; SHIFT is the "word in flight" state.
   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   // Bits needed to hold a count from 0 up to and including width.
   function automatic int counter_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bit_down_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bit_down_counter
//  Brief    : Loadable down-counter with enable. Decrements only while
//             nonzero, so it cannot wrap. Flags the final count of one.
//  Revision : 1.0  initial release
// ============================================================================
module bit_down_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             en,
   output logic             is_one
);

   logic [CNT_W-1:0] count;

   // Reset clears, load has priority over decrement, decrement stops at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (en && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign is_one = (count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/serial_bit_source.sv
`default_nettype none
// ============================================================================
//  Module   : serial_bit_source
//  Brief    : Captures a WIDTH-bit word on a valid/ready handshake and presents
//             it one bit per enabled cycle on x, qualified by x_valid. A new
//             word may be accepted on the last-bit advance for gapless output.
//  Revision : 1.0  initial release
// ============================================================================
module serial_bit_source
   import serial_bit_source_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic             bit_en,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = counter_width(WIDTH);

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shifted;
   logic             out_bit;
   logic             is_one;
   logic             in_shift;
   logic             advance;
   logic             last_adv;
   logic             handshake;

   assign in_shift  = (state == S_SHIFT);
   assign advance   = in_shift & bit_en;
   // Last bit is being consumed on this edge; frees the slot for a new word.
   assign last_adv  = advance & is_one;
   assign load_ready = (state == S_IDLE) | last_adv;
   assign handshake = load_valid & load_ready;

   // Bit ordering: which end of the register drives x, and which way it moves.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign out_bit = shreg[WIDTH-1];
         assign shifted = {shreg[WIDTH-2:0], 1'b0};
      end else begin : g_lsb_first
         assign out_bit = shreg[0];
         assign shifted = {1'b0, shreg[WIDTH-1:1]};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state: enter SHIFT on a load, leave only when the last bit goes
   // without a coincident reload.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (handshake) begin
               next_state = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (last_adv && !handshake) begin
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Shift register: capture on handshake, otherwise move toward x on advance.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg <= '0;
      end else if (handshake) begin
         shreg <= data_in;
      end else if (advance) begin
         shreg <= shifted;
      end
   end

   // Bits remaining in the current word.
   bit_down_counter #(
      .CNT_W (CNT_W)
   ) u_bit_cnt (
      .clk        (clk),
      .reset      (reset),
      .load       (handshake),
      .load_value (CNT_W'(WIDTH)),
      .en         (advance),
      .is_one     (is_one)
   );

   // End-of-word pulse, one cycle after the last bit is consumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         done <= 1'b0;
      end else begin
         done <= last_adv;
      end
   end

   assign x       = in_shift & out_bit;
   assign x_valid = in_shift;
   assign busy    = in_shift;

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_source.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_bit_source
//  Brief    : Directed self-checking bench. Two instances share all inputs:
//             one MSB-first, one LSB-first, both WIDTH=8.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_bit_source;

   logic       clk = 1'b0;
   logic       reset;
   logic       load_valid;
   logic [7:0] data_in;
   logic       bit_en;

   logic m_load_ready, m_x, m_x_valid, m_busy, m_done;
   logic l_load_ready, l_x, l_x_valid, l_busy, l_done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (m_load_ready),
      .data_in    (data_in),
      .bit_en     (bit_en),
      .x          (m_x),
      .x_valid    (m_x_valid),
      .busy       (m_busy),
      .done       (m_done)
   );

   serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (l_load_ready),
      .data_in    (data_in),
      .bit_en     (bit_en),
      .x          (l_x),
      .x_valid    (l_x_valid),
      .busy       (l_busy),
      .done       (l_done)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic check(input string tag, input logic [31:0] actual,
                        input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the idle/ready face of both instances.
   task automatic check_idle(input string tag);
      check({tag, "_m_xv"}, 32'(m_x_valid), 32'd0);
      check({tag, "_m_x"},  32'(m_x), 32'd0);
      check({tag, "_m_rdy"}, 32'(m_load_ready), 32'd1);
      check({tag, "_m_busy"}, 32'(m_busy), 32'd0);
      check({tag, "_l_xv"}, 32'(l_x_valid), 32'd0);
      check({tag, "_l_rdy"}, 32'(l_load_ready), 32'd1);
   endtask

   // Check bit k of word w on both instances while in flight.
   task automatic check_bit(input string tag, input logic [7:0] w, input int k,
                            input logic exp_done);
      logic [7:0] wv;
      wv = w;
      check({tag, "_m_x"}, 32'(m_x), 32'(wv[7-k]));
      check({tag, "_l_x"}, 32'(l_x), 32'(wv[k]));
      check({tag, "_m_xv"}, 32'(m_x_valid), 32'd1);
      check({tag, "_m_busy"}, 32'(m_busy), 32'd1);
      check({tag, "_m_done"}, 32'(m_done), 32'(exp_done));
      check({tag, "_l_done"}, 32'(l_done), 32'(exp_done));
   endtask

   // Load w, stream it out with an optional stall of stall_len cycles
   // placed before bit stall_at advances, then check the done pulse.
   task automatic run_word(input string tag, input logic [7:0] w,
                           input int stall_at, input int stall_len);
      load_valid = 1'b1;
      data_in    = w;
      bit_en     = 1'b1;
      check({tag, "_rdy_load"}, 32'(m_load_ready), 32'd1);
      tick();
      load_valid = 1'b0;
      data_in    = ~w;
      for (int k = 0; k < 8; k++) begin
         if (k == stall_at) begin
            bit_en = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               check_bit({tag, "_stall"}, w, k, 1'b0);
               check({tag, "_stall_rdy"}, 32'(m_load_ready), 32'd0);
               tick();
            end
            bit_en = 1'b1;
         end
         check_bit({tag, "_bit"}, w, k, 1'b0);
         tick();
      end
      check({tag, "_m_done"}, 32'(m_done), 32'd1);
      check({tag, "_l_done"}, 32'(l_done), 32'd1);
      check_idle({tag, "_end"});
      tick();
      check({tag, "_done_clr"}, 32'(m_done), 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      load_valid = 1'b0;
      data_in    = 8'h00;
      bit_en     = 1'b0;
      tick();
      tick();
      check_idle("rst");
      check("rst_m_done", 32'(m_done), 32'd0);
      reset = 1'b0;
      tick();
      check_idle("post_rst");

      // Plain streams; A5 is a bit-palindrome, 01 exposes ordering.
      run_word("a5", 8'hA5, -1, 0);
      run_word("01", 8'h01, -1, 0);
      // Stall for 3 cycles after two bits have gone.
      run_word("f0_stall", 8'hF0, 2, 3);

      // Back-to-back: FF then 00 loaded on the last-bit advance.
      load_valid = 1'b1;
      data_in    = 8'hFF;
      bit_en     = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int k = 0; k < 7; k++) begin
         check_bit("b2b_ff", 8'hFF, k, 1'b0);
         tick();
      end
      check_bit("b2b_ff_last", 8'hFF, 7, 1'b0);
      load_valid = 1'b1;
      data_in    = 8'h00;
      check("b2b_rdy_last", 32'(m_load_ready), 32'd1);
      tick();
      load_valid = 1'b0;
      data_in    = 8'hFF;
      check_bit("b2b_00_first", 8'h00, 0, 1'b1);
      tick();
      for (int k = 1; k < 8; k++) begin
         check_bit("b2b_00", 8'h00, k, 1'b0);
         tick();
      end
      check("b2b_done2", 32'(m_done), 32'd1);
      check_idle("b2b_end");
      tick();

      // Reset mid-word after three bits: word discarded, no done pulse.
      load_valid = 1'b1;
      data_in    = 8'hC3;
      tick();
      load_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check_bit("c3", 8'hC3, k, 1'b0);
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle("c3_rst");
      check("c3_rst_done", 32'(m_done), 32'd0);
      tick();
      check("c3_no_done", 32'(m_done), 32'd0);
      check("c3_no_done_l", 32'(l_done), 32'd0);
      check_idle("c3_after");

      // load_valid held while busy is ignored until the last-bit advance.
      load_valid = 1'b1;
      data_in    = 8'h0F;
      tick();
      data_in    = 8'h55;
      for (int k = 0; k < 7; k++) begin
         check_bit("hold_0f", 8'h0F, k, 1'b0);
         check("hold_rdy_busy", 32'(m_load_ready), 32'd0);
         tick();
      end
      check_bit("hold_0f_last", 8'h0F, 7, 1'b0);
      check("hold_rdy_last", 32'(m_load_ready), 32'd1);
      tick();
      load_valid = 1'b0;
      check_bit("hold_55_first", 8'h55, 0, 1'b1);
      tick();
      for (int k = 1; k < 8; k++) begin
         check_bit("hold_55", 8'h55, k, 1'b0);
         tick();
      end
      check("hold_done", 32'(m_done), 32'd1);
      check_idle("hold_end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
